// File: rtl/stable_hold_arbiter_if.sv
// stable_hold_arbiter_if: requester/target bundle for stable_hold_arbiter.
// Valid/ready: a beat transfers on a rising clk edge where tgt_valid and
// tgt_ready are both high. Once tgt_valid rises, it and tgt_data hold until that
// edge or until the arbiter aborts on timeout. A requester holds req[i] and its
// req_data slice stable from request until gnt[i] falls.
interface stable_hold_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      tgt_valid;
    logic [DATA_W-1:0]         tgt_data;
    logic                      tgt_ready;
    logic                      busy;
    logic                      timeout;
    logic                      viol;
    logic [2:0]                viol_id;
    logic [7:0]                viol_count;

    // Arbiter side
    modport slave (
        input  req, req_data, tgt_ready,
        output gnt, tgt_valid, tgt_data, busy, timeout, viol, viol_id, viol_count
    );

    // Requester/target side
    modport master (
        output req, req_data, tgt_ready,
        input  gnt, tgt_valid, tgt_data, busy, timeout, viol, viol_id, viol_count
    );
endinterface

// File: rtl/stable_hold_arbiter.sv
// stable_hold_arbiter: round-robin arbiter sharing one single-beat target among
// NUM_REQ requesters. The winner's payload is latched at grant time, so the
// target always sees the data present when the request was accepted. A stalled
// target is abandoned after TIMEOUT cycles in GRANT.
// Optional feature macro: STABLE_HOLD_CHECK_EN builds a checker that flags a
// granted requester whose req or data changes while granted. Without it,
// viol/viol_id/viol_count are tied to zero.
module stable_hold_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    stable_hold_arbiter_if.slave  bus,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [2:0]          sel, sel_nxt;
    logic [2:0]          rr_ptr, rr_ptr_nxt;
    logic [7:0]          wait_cnt, wait_cnt_nxt;
    logic [NUM_REQ-1:0]  gnt_q, gnt_nxt;
    logic                tgt_valid_q, tgt_valid_nxt;
    logic [DATA_W-1:0]   tgt_data_q, tgt_data_nxt;
    logic                timeout_q, timeout_nxt;

    logic                any_req;
    logic [2:0]          pick;
    logic [DATA_W-1:0]   pick_data;

    // Round-robin pick: requester with the smallest upward distance from rr_ptr
    always_comb begin
        int best_d;
        int d;
        any_req   = 1'b0;
        pick      = '0;
        pick_data = '0;
        best_d    = NUM_REQ;
        d         = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            d = (j + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
            if (bus.req[j] && (d < best_d)) begin
                best_d    = d;
                any_req   = 1'b1;
                pick      = 3'(j);
                pick_data = bus.req_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // FSM state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= '0;
            rr_ptr      <= '0;
            wait_cnt    <= '0;
            gnt_q       <= '0;
            tgt_valid_q <= 1'b0;
            tgt_data_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            rr_ptr      <= rr_ptr_nxt;
            wait_cnt    <= wait_cnt_nxt;
            gnt_q       <= gnt_nxt;
            tgt_valid_q <= tgt_valid_nxt;
            tgt_data_q  <= tgt_data_nxt;
            timeout_q   <= timeout_nxt;
        end
    end

    // Next-state logic: grant in IDLE, complete or abort in GRANT, one dead cycle in RELEASE
    always_comb begin
        state_nxt     = state;
        sel_nxt       = sel;
        rr_ptr_nxt    = rr_ptr;
        wait_cnt_nxt  = wait_cnt;
        gnt_nxt       = gnt_q;
        tgt_valid_nxt = tgt_valid_q;
        tgt_data_nxt  = tgt_data_q;
        timeout_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    sel_nxt       = pick;
                    tgt_data_nxt  = pick_data;
                    for (int j = 0; j < NUM_REQ; j++) begin
                        gnt_nxt[j] = (j == int'(pick));
                    end
                    tgt_valid_nxt = 1'b1;
                    wait_cnt_nxt  = '0;
                    state_nxt     = GRANT;
                end
            end
            GRANT: begin
                if (tgt_valid_q && bus.tgt_ready) begin
                    gnt_nxt       = '0;
                    tgt_valid_nxt = 1'b0;
                    rr_ptr_nxt    = 3'((int'(sel) + 1) % NUM_REQ);
                    state_nxt     = RELEASE;
                end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                    // Abort: the pointer still advances so a dead target cannot starve others
                    timeout_nxt   = 1'b1;
                    gnt_nxt       = '0;
                    tgt_valid_nxt = 1'b0;
                    rr_ptr_nxt    = 3'((int'(sel) + 1) % NUM_REQ);
                    state_nxt     = RELEASE;
                end else begin
                    wait_cnt_nxt  = wait_cnt + 8'd1;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.tgt_valid = tgt_valid_q;
    assign bus.tgt_data  = tgt_data_q;
    assign bus.timeout   = timeout_q;
    assign bus.busy      = (state != IDLE);
    assign dbg_state     = state;

`ifdef STABLE_HOLD_CHECK_EN
    logic              sel_req;
    logic [DATA_W-1:0] sel_data;
    logic              mismatch;
    logic              viol_q;
    logic [2:0]        viol_id_q;
    logic [7:0]        viol_count_q;

    // Current req and data of the granted requester, compared to what was latched
    always_comb begin
        sel_req  = 1'b0;
        sel_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (j == int'(sel)) begin
                sel_req  = bus.req[j];
                sel_data = bus.req_data[j*DATA_W +: DATA_W];
            end
        end
        mismatch = (state == GRANT) && (!sel_req || (sel_data != tgt_data_q));
    end

    // Violation pulse, sticky id and saturating count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_q       <= 1'b0;
            viol_id_q    <= '0;
            viol_count_q <= '0;
        end else begin
            viol_q <= mismatch;
            if (mismatch) begin
                viol_id_q <= sel;
                if (viol_count_q != 8'hFF) begin
                    viol_count_q <= viol_count_q + 8'd1;
                end
            end
        end
    end

    assign bus.viol       = viol_q;
    assign bus.viol_id    = viol_id_q;
    assign bus.viol_count = viol_count_q;
`else
    assign bus.viol       = 1'b0;
    assign bus.viol_id    = 3'd0;
    assign bus.viol_count = 8'd0;
`endif

endmodule

// File: tb/tb_stable_hold_arbiter.sv
// tb_stable_hold_arbiter: directed bench for stable_hold_arbiter
// (NUM_REQ=4, DATA_W=8, TIMEOUT=15). Expectations for the violation outputs
// follow whether STABLE_HOLD_CHECK_EN is defined for the build.
module tb_stable_hold_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

`ifdef STABLE_HOLD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    int n_tests;
    int n_fail;

    stable_hold_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    stable_hold_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [DATA_W-1:0] val);
        bus.req_data[idx*DATA_W +: DATA_W] = val;
    endtask

    initial begin
        int vcnt;
        n_tests = 0;
        n_fail  = 0;

        rst           = 1'b1;
        bus.req       = '0;
        bus.req_data  = '0;
        bus.tgt_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset values
        check("rst_gnt",        32'(bus.gnt), 32'h0);
        check("rst_valid",      32'(bus.tgt_valid), 32'h0);
        check("rst_data",       32'(bus.tgt_data), 32'h0);
        check("rst_busy",       32'(bus.busy), 32'h0);
        check("rst_timeout",    32'(bus.timeout), 32'h0);
        check("rst_viol",       32'(bus.viol), 32'h0);
        check("rst_viol_id",    32'(bus.viol_id), 32'h0);
        check("rst_viol_count", 32'(bus.viol_count), 32'h0);
        check("rst_state",      32'(dbg_state), 32'h0);

        // Single request from requester 2, target ready
        bus.req       = 4'b0100;
        set_data(2, 8'hA5);
        bus.tgt_ready = 1'b1;
        step();
        check("single_gnt",   32'(bus.gnt), 32'h4);
        check("single_valid", 32'(bus.tgt_valid), 32'h1);
        check("single_data",  32'(bus.tgt_data), 32'hA5);
        check("single_busy1", 32'(bus.busy), 32'h1);
        step();
        check("single_gnt_drop",   32'(bus.gnt), 32'h0);
        check("single_valid_drop", 32'(bus.tgt_valid), 32'h0);
        check("single_busy2",      32'(bus.busy), 32'h1);
        bus.req = '0;
        step();
        check("single_busy_end", 32'(bus.busy), 32'h0);

        // Stability violation: requester 3 changes data on the handshake edge
        bus.req       = 4'b1000;
        set_data(3, 8'h11);
        bus.tgt_ready = 1'b0;
        step();
        check("viol_gnt", 32'(bus.gnt), 32'h8);
        step();
        check("viol_data_held", 32'(bus.tgt_data), 32'h11);
        check("viol_none_yet",  32'(bus.viol), 32'h0);
        set_data(3, 8'h22);
        bus.tgt_ready = 1'b1;
        step();
        check("viol_done_valid", 32'(bus.tgt_valid), 32'h0);
        check("viol_delivered",  32'(bus.tgt_data), 32'h11);
        check("viol_pulse",      32'(bus.viol), CHK ? 32'h1 : 32'h0);
        check("viol_id",         32'(bus.viol_id), CHK ? 32'h3 : 32'h0);
        check("viol_count",      32'(bus.viol_count), CHK ? 32'h1 : 32'h0);
        bus.req = '0;
        step();
        check("viol_pulse_end",  32'(bus.viol), 32'h0);
        check("viol_count_hold", 32'(bus.viol_count), CHK ? 32'h1 : 32'h0);
        check("viol_id_hold",    32'(bus.viol_id), CHK ? 32'h3 : 32'h0);

        // Reset mid-transfer
        bus.req       = 4'b0010;
        set_data(1, 8'h5C);
        bus.tgt_ready = 1'b0;
        step();
        check("mid_gnt",   32'(bus.gnt), 32'h2);
        check("mid_valid", 32'(bus.tgt_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_gnt",        32'(bus.gnt), 32'h0);
        check("mid_rst_valid",      32'(bus.tgt_valid), 32'h0);
        check("mid_rst_busy",       32'(bus.busy), 32'h0);
        check("mid_rst_viol_count", 32'(bus.viol_count), 32'h0);
        check("mid_rst_data",       32'(bus.tgt_data), 32'h0);
        step();
        rst = 1'b0;

        // Round-robin with every requester holding, target ready
        bus.req       = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'(8'h10 + i));
        bus.tgt_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            step();
            check($sformatf("rr_gnt%0d", g),  32'(bus.gnt), 32'(1 << (g % NUM_REQ)));
            check($sformatf("rr_data%0d", g), 32'(bus.tgt_data), 32'(8'h10 + (g % NUM_REQ)));
            step();
            check($sformatf("rr_rel%0d", g),  32'({bus.tgt_valid, bus.busy}), 32'h1);
            step();
            check($sformatf("rr_idle%0d", g), 32'({bus.gnt, bus.busy}), 32'h0);
        end
        bus.req = '0;

        // Backpressure and timeout: pointer is at 1, requesters 1 and 2 ask
        bus.req       = 4'b0110;
        set_data(1, 8'h77);
        set_data(2, 8'h88);
        bus.tgt_ready = 1'b0;
        step();
        check("to_gnt", 32'(bus.gnt), 32'h2);
        vcnt = 0;
        for (int c = 0; c < 40 && bus.tgt_valid; c++) begin
            vcnt++;
            step();
        end
        check("to_valid_cycles", 32'(vcnt), 32'(TIMEOUT));
        check("to_pulse",        32'(bus.timeout), 32'h1);
        check("to_gnt_drop",     32'(bus.gnt), 32'h0);
        check("to_busy_rel",     32'(bus.busy), 32'h1);
        bus.req = 4'b0100;
        step();
        check("to_pulse_end", 32'(bus.timeout), 32'h0);
        check("to_idle",      32'(bus.busy), 32'h0);
        bus.tgt_ready = 1'b1;
        step();
        check("to_next_gnt",  32'(bus.gnt), 32'h4);
        check("to_next_data", 32'(bus.tgt_data), 32'h88);
        step();
        bus.req = '0;
        step();
        check("final_idle",       32'(dbg_state), 32'h0);
        check("final_viol_count", 32'(bus.viol_count), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stable_hold_arbiter.md
# stable_hold_arbiter

Round-robin arbiter that shares one single-beat target port among NUM_REQ requesters using a valid/ready handshake. Each requester must hold `req` and its data stable from request until its grant drops. The block latches the winner's data, drives the target, and times out stalled targets. An optional checker flags requester stability violations, which makes the block the enforcement point for the hold-stable protocol that our `$stable` assertions check.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, payload width per requester
- TIMEOUT, 15, maximum cycles in GRANT waiting for `tgt_ready` (1..255)

- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  request per requester
- req_data  in  NUM_REQ*DATA_W  payload, requester i at bits [i*DATA_W +: DATA_W]
- gnt  out  NUM_REQ  one-hot grant, registered
- tgt_valid  out  1  target beat valid, registered
- tgt_data  out  DATA_W  latched payload of granted requester
- tgt_ready  in  1  target accepts beat
- busy  out  1  high in GRANT or RELEASE
- timeout  out  1  one-cycle pulse on a handshake abort
- viol  out  1  one-cycle pulse on a stability violation
- viol_id  out  3  index of violating requester, held until the next violation
- viol_count  out  8  saturating violation count

## Operation
- FSM states: IDLE, GRANT, RELEASE. Reset state is IDLE.
- IDLE: if any `req` is high, select the first set index at or after `rr_ptr`, scanning upward modulo NUM_REQ.
  - Latch `sel` and `req_data[sel]` into `tgt_data`.
  - Set `gnt[sel]=1` and `tgt_valid=1`, then go to GRANT.
  - Clear `wait_cnt`.
- GRANT: hold `gnt`, `tgt_valid` and `tgt_data`.
  - If `tgt_valid && tgt_ready`: clear `gnt` and `tgt_valid`, set `rr_ptr = (sel+1) mod NUM_REQ`, go to RELEASE.
  - Otherwise, if `wait_cnt == TIMEOUT-1`: pulse `timeout`, clear `gnt` and `tgt_valid`, advance `rr_ptr` the same way, go to RELEASE.
  - Otherwise increment `wait_cnt`.
- RELEASE: one dead cycle with no grant, then go to IDLE. The requester must drop `req` during this cycle. A `req` still high in IDLE is treated as a new request.
- A `req[sel]` that drops during GRANT does not abort the transfer. The latched data is still delivered.
- Data width: `tgt_data` is exactly DATA_W with no transformation. `wait_cnt` is 8 bits.

## Timing
- Reset values:
  - `gnt=0`, `tgt_valid=0`, `tgt_data=0`, `busy=0`
  - `timeout=0`, `viol=0`, `viol_id=0`, `viol_count=0`
  - `rr_ptr=0`, state IDLE
- Request to grant: `req` high at edge k in IDLE → `gnt` and `tgt_valid` high after edge k.
- If `tgt_ready` is already high, the handshake completes at edge k+1. `tgt_valid` is high for exactly one cycle.
- Minimum spacing is 3 cycles per transfer: grant edge, handshake edge, RELEASE edge.
- Timeout: with `tgt_ready` held low, `tgt_valid` stays high for exactly TIMEOUT cycles, and `timeout` pulses in the cycle after the abort edge.
- Requests arriving while not in IDLE are only sampled in IDLE.
- Asserting `rst` mid-transfer clears all outputs immediately. No beat is presented after release.

## Configuration
- `STABLE_HOLD_CHECK_EN` defined: the stability checker is compiled in.
  - Every cycle in GRANT, compare `req[sel]` against 1 and `req_data[sel]` against the latched `tgt_data`.
  - On any mismatch at an edge: pulse `viol` in the next cycle, load `viol_id=sel`, and increment `viol_count`, saturating at 255.
  - At most one violation per cycle.
- Not defined: no comparison logic is built. `viol`, `viol_id` and `viol_count` are tied to 0. Arbitration and timeout are unchanged.

## Test plan
- Single request: `req=4'b0100`, `req_data[2]=8'hA5`, `tgt_ready=1` → `gnt=4'b0100` and `tgt_data=8'hA5` for 1 cycle, `busy` high for 2 cycles.
- Round-robin: all `req` held high, `tgt_ready=1` → grants in order 0,1,2,3,0, one grant every 3 cycles.
- Backpressure and timeout: `req[1]=1`, `tgt_ready=0`, TIMEOUT=15 → `tgt_valid` high for exactly 15 cycles, then one `timeout` pulse, and the next grant goes to requester 2 if it is requesting.
- Stability violation (macro defined): `req_data[3]` changes 8'h11→8'h22 while granted → one `viol` pulse, `viol_id=3`, `viol_count=1`, delivered `tgt_data=8'h11`.
- Reset mid-transfer: `rst` asserted during GRANT → `gnt`, `tgt_valid`, `busy` and `viol_count` read 0 immediately. After release, the first grant goes to requester 0.
- Macro undefined: repeat the violation scenario → `viol` and `viol_count` stay 0 and the transfer still completes.
